tdc_fifo_arbiter: RTL and testbench

TDC_FIFO_ARBITER -- requirements
Module: tdc_fifo_arbiter

---
 rtl/tdc_fifo_arbiter.sv | 118 +++++++++++
 tb/tb_tdc_fifo_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_fifo_arbiter.sv
// Round-robin merger of TDC FIFOs into a single valid/ready output stream.
// One word is moved per IDLE -> READ -> CAPTURE -> OUTPUT pass.
module tdc_fifo_arbiter #(
    parameter int TDC_COUNT      = 10,
    parameter int TDC_DATA_WIDTH = 40
) (
    input  logic                                sys_clk_160,
    input  logic                                rst_160_n,
    input  logic                                enable,
    input  logic                                clear_counters,
    input  logic [TDC_COUNT-1:0]                tdc_fifo_empty,
    input  logic [TDC_COUNT*TDC_DATA_WIDTH-1:0] tdc_fifo_data,
    output logic [TDC_COUNT-1:0]                tdc_fifo_read,
    output logic [TDC_DATA_WIDTH-1:0]           out_data,
    output logic [3:0]                          out_tdc_idx,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [31:0]                         word_count,
    output logic                                arb_busy
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CAPTURE,
        OUTPUT
    } state_t;

    state_t                    state;
    logic [3:0]                ptr;
    logic [3:0]                grant;
    logic [3:0]                next_grant;
    logic [3:0]                cand;
    logic                      any_ready;
    int                        sum;
    logic [TDC_DATA_WIDTH-1:0] words [TDC_COUNT];

    // Split the flat data bus into one word per FIFO
    always_comb begin
        for (int j = 0; j < TDC_COUNT; j++) begin
            words[j] = tdc_fifo_data[j*TDC_DATA_WIDTH +: TDC_DATA_WIDTH];
        end
    end

    // Round-robin search from ptr+1 upward; walking backwards lets the nearest hit win
    always_comb begin
        next_grant = ptr;
        any_ready  = 1'b0;
        sum        = 0;
        cand       = '0;
        for (int k = TDC_COUNT; k >= 1; k--) begin
            sum = int'(ptr) + k;
            if (sum >= TDC_COUNT) begin
                sum = sum - TDC_COUNT;
            end
            cand = 4'(sum);
            if (!tdc_fifo_empty[cand]) begin
                next_grant = cand;
                any_ready  = 1'b1;
            end
        end
    end

    // Arbitration FSM with registered strobe and output word
    always_ff @(posedge sys_clk_160 or negedge rst_160_n) begin
        if (!rst_160_n) begin
            state         <= IDLE;
            ptr           <= 4'(TDC_COUNT - 1);
            grant         <= '0;
            tdc_fifo_read <= '0;
            out_data      <= '0;
            out_tdc_idx   <= '0;
            out_valid     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (enable && any_ready) begin
                        grant         <= next_grant;
                        tdc_fifo_read <= TDC_COUNT'(1) << next_grant;
                        state         <= READ;
                    end
                end
                READ: begin
                    tdc_fifo_read <= '0;
                    ptr           <= grant;
                    state         <= CAPTURE;
                end
                CAPTURE: begin
                    out_data    <= words[grant];
                    out_tdc_idx <= grant;
                    out_valid   <= 1'b1;
                    state       <= OUTPUT;
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Count accepted words; clear wins over a simultaneous handshake
    always_ff @(posedge sys_clk_160 or negedge rst_160_n) begin
        if (!rst_160_n) begin
            word_count <= '0;
        end else if (clear_counters) begin
            word_count <= '0;
        end else if (out_valid && out_ready) begin
            word_count <= word_count + 32'd1;
        end
    end

    assign arb_busy = (state != IDLE);

endmodule

// File: tb/tb_tdc_fifo_arbiter.sv
// Randomised and directed bench for tdc_fifo_arbiter.
// FIFOs are emulated with queues; a transaction-level model predicts grants and words.
module tb_tdc_fifo_arbiter;

    localparam int N = 10;
    localparam int W = 40;

    typedef logic [W-1:0] word_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enable = 1'b0;
    logic           clr = 1'b0;
    logic           ready = 1'b0;
    logic [N-1:0]   empty = '1;
    logic [N*W-1:0] data;
    logic [N-1:0]   rd;
    word_t          out_data;
    logic [3:0]     out_idx;
    logic           out_valid;
    logic [31:0]    word_count;
    logic           busy;

    always #5 clk = ~clk;

    tdc_fifo_arbiter #(
        .TDC_COUNT(N),
        .TDC_DATA_WIDTH(W)
    ) dut (
        .sys_clk_160(clk),
        .rst_160_n(rst_n),
        .enable(enable),
        .clear_counters(clr),
        .tdc_fifo_empty(empty),
        .tdc_fifo_data(data),
        .tdc_fifo_read(rd),
        .out_data(out_data),
        .out_tdc_idx(out_idx),
        .out_valid(out_valid),
        .out_ready(ready),
        .word_count(word_count),
        .arb_busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // FIFO emulation
    word_t q [N][$];
    word_t lane [N] = '{default: '0};

    always_comb begin
        data = '0;
        for (int j = 0; j < N; j++) data[j*W +: W] = lane[j];
    end

    // Reference model state
    int          last = N - 1;
    word_t       exp_q[$];
    int          exp_idx_q[$];
    int          served[$];
    logic [31:0] wc = '0;
    int          hs_total = 0;
    int          reads_total = 0;
    int          since_read = 100;
    logic        prev_valid = 1'b0;
    word_t       prev_data = '0;
    logic [3:0]  prev_idx = '0;
    logic        force_evt = 1'b0;
    int          g;
    int          idx;

    // Inputs seen here are exactly those the DUT sampled at the preceding edge
    always @(negedge clk) begin
        if (!rst_n) begin
            last       = N - 1;
            exp_q.delete();
            exp_idx_q.delete();
            wc         = '0;
            prev_valid = 1'b0;
            since_read = 100;
        end else begin
            since_read++;
            if (prev_valid && ready) begin
                hs_total++;
                served.push_back(int'(prev_idx));
                if (exp_q.size() == 0) begin
                    chk("hs_unexpected", 1, 0);
                end else begin
                    chk("out_data", prev_data, exp_q.pop_front());
                    chk("out_idx", prev_idx, exp_idx_q.pop_front());
                end
            end
            if (prev_valid && !ready)
                chk("hold", {out_valid, out_idx, out_data},
                    {1'b1, prev_idx, prev_data});
            if (force_evt) wc = 32'hFFFF_FFFF;
            if (clr) wc = '0;
            else if (prev_valid && ready) wc = wc + 1;
            chk("word_count", word_count, wc);
            if (rd != '0) begin
                reads_total++;
                chk("read_onehot", $countones(rd), 1);
                chk("read_enable", enable, 1);
                g = -1;
                for (int k = N; k >= 1; k--)
                    if (!empty[(last + k) % N]) g = (last + k) % N;
                chk("grant", rd, (g < 0) ? 64'd0 : (64'd1 << g));
                chk("spacing", since_read >= 4, 1);
                since_read = 0;
                idx = 0;
                for (int j = 0; j < N; j++) if (rd[j]) idx = j;
                last = (g < 0) ? idx : g;
                if (q[idx].size() > 0) lane[idx] = q[idx].pop_front();
                exp_q.push_back(lane[idx]);
                exp_idx_q.push_back(idx);
            end
            prev_valid = out_valid;
            prev_data  = out_data;
            prev_idx   = out_idx;
        end
        for (int j = 0; j < N; j++) empty[j] = (q[j].size() == 0);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic word_t rnd_word();
        return word_t'({$urandom, $urandom});
    endfunction

    task automatic wait_hs(input int target, input int max);
        int t = 0;
        while (hs_total < target && t < max) begin
            tick();
            t++;
        end
        chk("timeout_hs", hs_total >= target, 1);
    endtask

    task automatic wait_valid(input int max);
        int t = 0;
        while (!out_valid && t < max) begin
            tick();
            t++;
        end
        chk("timeout_valid", out_valid, 1);
    endtask

    task automatic wait_read(input int max);
        int t = 0;
        while (rd == '0 && t < max) begin
            tick();
            t++;
        end
        chk("timeout_read", rd != '0, 1);
    endtask

    int h0;
    int r0;

    initial begin
        tick(3);
        chk("rst_read", rd, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_wc", word_count, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;

        // Round robin across 0, 3, 9 then back to 0
        q[0].push_back(rnd_word());
        q[3].push_back(rnd_word());
        q[9].push_back(rnd_word());
        q[0].push_back(rnd_word());
        enable = 1'b1;
        ready  = 1'b1;
        wait_hs(3, 100);
        chk("wc_after3", word_count, 3);
        wait_hs(4, 100);
        chk("order0", served[0], 0);
        chk("order1", served[1], 3);
        chk("order2", served[2], 9);
        chk("order3", served[3], 0);
        tick(5);

        // Back-pressure on a single FIFO
        ready = 1'b0;
        r0 = reads_total;
        h0 = hs_total;
        q[5].push_back(40'h12_3456_789A);
        wait_valid(20);
        repeat (10) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 40'h12_3456_789A);
            chk("bp_idx", out_idx, 5);
            tick();
        end
        ready = 1'b1;
        wait_hs(h0 + 1, 20);
        chk("bp_reads", reads_total - r0, 1);
        tick(3);

        // Enable dropped while capturing
        ready = 1'b0;
        h0 = hs_total;
        q[2].push_back(rnd_word());
        q[2].push_back(rnd_word());
        q[7].push_back(rnd_word());
        q[7].push_back(rnd_word());
        wait_read(20);
        tick();
        enable = 1'b0;
        ready  = 1'b1;
        wait_hs(h0 + 1, 20);
        r0 = reads_total;
        tick(20);
        chk("dis_reads", reads_total - r0, 0);
        chk("dis_busy", busy, 0);
        enable = 1'b1;
        wait_hs(h0 + 4, 100);
        tick(3);

        // Counter wrap and clear priority
        ready = 1'b0;
        force dut.word_count = 32'hFFFF_FFFF;
        force_evt = 1'b1;
        #1;
        release dut.word_count;
        tick();
        force_evt = 1'b0;
        chk("wc_preset", word_count, 32'hFFFF_FFFF);
        h0 = hs_total;
        q[1].push_back(rnd_word());
        ready = 1'b1;
        wait_hs(h0 + 1, 20);
        chk("wc_wrap", word_count, 0);
        ready = 1'b0;
        q[4].push_back(rnd_word());
        wait_valid(20);
        tick();
        chk("wc_one_pre", word_count, 0);
        ready = 1'b1;
        clr   = 1'b1;
        tick();
        clr   = 1'b0;
        ready = 1'b0;
        chk("wc_clear", word_count, 0);
        tick(3);

        // Reset while presenting a word; next grant restarts at index 0
        q[8].push_back(rnd_word());
        wait_valid(20);
        chk("pre_rst_idx", out_idx, 8);
        q[2].push_back(rnd_word());
        q[9].push_back(rnd_word());
        tick(2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_read", rd, 0);
        tick(2);
        rst_n = 1'b1;
        ready = 1'b1;
        h0 = hs_total;
        wait_read(20);
        chk("post_rst_grant", rd, 64'd1 << 2);
        wait_hs(h0 + 2, 50);
        tick(3);

        // Everything empty: no activity
        enable = 1'b1;
        repeat (100) begin
            chk("idle_quiet", {busy, rd}, 0);
            tick();
        end

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(4) == 0) begin
                int j = $urandom_range(N - 1);
                if (q[j].size() < 4) q[j].push_back(rnd_word());
            end
            ready = ($urandom_range(3) != 0);
            if ($urandom_range(49) == 0) enable = ~enable;
            clr = ($urandom_range(99) == 0);
            tick();
        end
        enable = 1'b1;
        ready  = 1'b1;
        clr    = 1'b0;
        tick(300);
        chk("drained_exp", exp_q.size(), 0);
        chk("drained_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
